// File: rtl/add_seq_pkg.sv
// rtl/add_seq_pkg.sv - shared constants and state encoding for the add_seq16 sequencer
package add_seq_pkg;

    localparam int ADD_SEQ_W   = 16;
    localparam int ADD_SEQ_NIB = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/add_seq16_cla4.sv
// rtl/add_seq16_cla4.sv - 4-bit carry-lookahead adder slice with group propagate/generate
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       pg,
    output logic       gg
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is flattened from cin so no ripple path exists inside the slice.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = gg | (pg & cin);

    assign pg = &p;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

    assign s    = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/add_seq16.sv
// rtl/add_seq16.sv - 16-bit add/subtract sequencer, one nibble per cycle; ADD_SEQ_SUB_EN adds the sub port
module add_seq16
    import add_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADD_SEQ_W-1:0] a,
    input  logic [ADD_SEQ_W-1:0] b,
    input  logic                 cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic                 sub,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADD_SEQ_W-1:0] sum,
    output logic                 cout,
    output logic                 ofl,
    output logic                 zero
);

    state_t                 state;
    state_t                 state_nxt;
    logic [ADD_SEQ_W-1:0]   a_q;
    logic [ADD_SEQ_W-1:0]   b_q;
    logic                   c_q;
    logic [1:0]             cnt;
    logic                   accept;
    logic [ADD_SEQ_W-1:0]   b_eff;
    logic                   c_eff;
    logic [ADD_SEQ_NIB-1:0] nib_a;
    logic [ADD_SEQ_NIB-1:0] nib_b;
    logic [ADD_SEQ_NIB-1:0] nib_s;
    logic                   nib_c;

`ifdef ADD_SEQ_SUB_EN
    // Subtract is a + ~b + 1, so cin has no meaning when sub is set.
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub ? 1'b1 : cin;
`else
    assign b_eff = b;
    assign c_eff = cin;
`endif

    assign accept = in_valid & in_ready;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (cnt == 2'd3) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    assign nib_a = a_q[{cnt, 2'b00} +: ADD_SEQ_NIB];
    assign nib_b = b_q[{cnt, 2'b00} +: ADD_SEQ_NIB];

    cla4 u_cla4 (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (c_q),
        .s    (nib_s),
        .cout (nib_c),
        .pg   (),
        .gg   ()
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= 1'b0;
            cnt <= 2'd0;
            sum <= '0;
        end else if (accept) begin
            a_q <= a;
            b_q <= b_eff;
            c_q <= c_eff;
            cnt <= 2'd0;
            sum <= '0;
        end else if (state == RUN) begin
            sum[{cnt, 2'b00} +: ADD_SEQ_NIB] <= nib_s;
            c_q <= nib_c;
            cnt <= cnt + 2'd1;
        end
    end

    // Result flags decode held registers so they stay valid in IDLE until the next accept.
    assign cout = c_q;
    assign ofl  = (a_q[ADD_SEQ_W-1] == b_q[ADD_SEQ_W-1]) & (sum[ADD_SEQ_W-1] != a_q[ADD_SEQ_W-1]);
    assign zero = ~|sum;

endmodule

// File: tb/tb_add_seq16.sv
// tb/tb_add_seq16.sv - scoreboard bench for add_seq16 against an arithmetic reference model
module tb_add_seq16;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ofl;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ofl;
    logic        zero;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    add_seq16 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADD_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ofl       (ofl),
        .zero      (zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    // Reference: plain integer arithmetic, subtract as a + ~b + 1.
    function automatic exp_t model(input logic [15:0] oa, input logic [15:0] ob,
                                   input logic oc, input logic os);
        exp_t        e;
        logic [15:0] bb;
        logic        c;
        int          ua;
        int          ub;
        int          us;
        int          sr;
        bb = os ? ~ob : ob;
        c  = os ? 1'b1 : oc;
        ua = int'(oa);
        ub = int'(bb);
        us = ua + ub + int'(c);
        sr = int'($signed(oa)) + int'($signed(bb)) + int'(c);
        e.sum  = us[15:0];
        e.cout = us > 65535;
        e.ofl  = (sr > 32767) || (sr < -32768);
        e.zero = (us[15:0] == 16'h0000);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum",  32'(sum),  32'(e.sum));
                check("cout", 32'(cout), 32'(e.cout));
                check("ofl",  32'(ofl),  32'(e.ofl));
                check("zero", 32'(zero), 32'(e.zero));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_wait", 32'(in_ready), 32'd1);
    endtask

    task automatic do_op(input logic [15:0] oa, input logic [15:0] ob,
                         input logic oc, input logic os_in, input int hold);
        exp_t e;
        int   n;
        logic os;
`ifdef ADD_SEQ_SUB_EN
        os = os_in;
`else
        os = 1'b0 & os_in;
`endif
        e = model(oa, ob, oc, os);
        wait_idle();
        a = oa; b = ob; cin = oc; sub = os; in_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), 32'd4);
        repeat (hold) begin
            in_valid = 1'($urandom);
            a = 16'($urandom);
            @(posedge clk); #1;
            check("bp_sum", 32'(sum), 32'(e.sum));
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("ready_after", 32'(in_ready), 32'd1);
        check("valid_after", 32'(out_valid), 32'd0);
        check("held_sum", 32'(sum), 32'(e.sum));
        check("held_cout", 32'(cout), 32'(e.cout));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ofl", 32'(ofl), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);

        do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1);
        do_op(16'h8000, 16'h8000, 1'b1, 1'b0, 3);

        // Abort with cnt==2, then confirm reset beats a simultaneous request in IDLE.
        wait_idle();
        a = 16'hABCD; b = 16'h1357; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        exp_q.push_back(model(16'hABCD, 16'h1357, 1'b1, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        void'(exp_q.pop_back());
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_zero", 32'(zero), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("rst_wins_in_ready", 32'(in_ready), 32'd1);
        check("rst_wins_sum", 32'(sum), 32'd0);
        do_op(16'h0003, 16'h0004, 1'b0, 1'b0, 0);

        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1);
        do_op(16'h0000, 16'h0000, 1'b0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 2)));
        end

        repeat (3) @(posedge clk);
        #1 check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
